// File: rtl/output_memory_manager.sv
// Collects groups of four 16-bit lane results and writes them one word per cycle
// into the shared 512x16 vector memory, flagging layer_done after RESULT_COUNT words.
module output_memory_manager #(
  parameter logic [8:0] BASE_ADDRESS = 9'h100,
  parameter int         RESULT_COUNT = 144
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        en,
  input  logic        results_valid,
  input  logic [15:0] r0_element,
  input  logic [15:0] r1_element,
  input  logic [15:0] r2_element,
  input  logic [15:0] r3_element,
  output logic        results_ready,
  output logic [8:0]  vector_memory_address,
  output logic        memory_enable,
  output logic        memory_write,
  output logic [15:0] vector_write_element,
  output logic        layer_done,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [9:0] LAST_COUNT = 10'(RESULT_COUNT);

  logic [1:0]  state;
  logic [1:0]  lane;
  logic [8:0]  write_count;
  logic [15:0] buffer [4];
  logic        last_group;
  logic        accept;

  assign fsm_state  = state;
  assign last_group = ({1'b0, write_count} + 10'd1) == LAST_COUNT;

  // Handshake: a group transfers on a rising edge where results_valid && results_ready.
  // Ready never depends on valid; a new group is taken either from IDLE or on the
  // final word of the current group so that held-valid traffic streams without gaps.
  always_comb begin
    results_ready = 1'b0;
    case (state)
      IDLE:    results_ready = en && !layer_done;
      WRITE:   results_ready = en && (lane == 2'd3) && !last_group;
      default: results_ready = 1'b0;
    endcase
  end

  assign accept = results_valid && results_ready;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state                 <= IDLE;
      lane                  <= 2'd0;
      write_count           <= 9'd0;
      for (int i = 0; i < 4; i++) buffer[i] <= 16'd0;
      memory_enable         <= 1'b0;
      memory_write          <= 1'b0;
      vector_memory_address <= 9'd0;
      vector_write_element  <= 16'd0;
      layer_done            <= 1'b0;
    end else begin
      memory_enable <= 1'b0;
      memory_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            buffer[0] <= r0_element;
            buffer[1] <= r1_element;
            buffer[2] <= r2_element;
            buffer[3] <= r3_element;
            lane      <= 2'd0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (en) begin
            memory_enable         <= 1'b1;
            memory_write          <= 1'b1;
            vector_memory_address <= BASE_ADDRESS + write_count;
            vector_write_element  <= buffer[lane];
            write_count           <= write_count + 9'd1;
            // lane wraps 3 -> 0, which is exactly the restart point for a reloaded group
            lane                  <= lane + 2'd1;
            if (lane == 2'd3) begin
              if (last_group) begin
                layer_done <= 1'b1;
                state      <= DONE;
              end else if (accept) begin
                buffer[0] <= r0_element;
                buffer[1] <= r1_element;
                buffer[2] <= r2_element;
                buffer[3] <= r3_element;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_memory_manager.sv
// Bench for output_memory_manager: three configurations share one stimulus stream and
// each is checked against a word-queue model of the writes it must perform.
module tb_output_memory_manager;

  localparam logic [8:0] BASE_TAB  [3] = '{9'h100, 9'h100, 9'h1FE};
  localparam int         COUNT_TAB [3] = '{144, 8, 144};

  logic        clock = 1'b0;
  logic        clear_n, en, results_valid;
  logic [15:0] r0, r1, r2, r3;

  logic        ready  [3];
  logic [8:0]  addr   [3];
  logic        mem_en [3];
  logic        mem_wr [3];
  logic [15:0] wdata  [3];
  logic        done   [3];
  logic [1:0]  dbg    [3];

  int vectors = 0;
  int errors  = 0;

  // Model state: words still owed to memory as {addr, data}, and per-layer bookkeeping.
  logic [24:0] exp_q [3][$];
  int          acc_cnt    [3];
  logic        exp_strobe [3];
  logic        exp_done   [3];
  logic [8:0]  last_addr  [3];
  logic [15:0] last_data  [3];
  logic [24:0] mon_w;
  logic        mon_pred;

  always #5 clock = ~clock;

  output_memory_manager #(.BASE_ADDRESS(9'h100), .RESULT_COUNT(144)) u_a (
    .clock(clock), .clear_n(clear_n), .en(en), .results_valid(results_valid),
    .r0_element(r0), .r1_element(r1), .r2_element(r2), .r3_element(r3),
    .results_ready(ready[0]), .vector_memory_address(addr[0]), .memory_enable(mem_en[0]),
    .memory_write(mem_wr[0]), .vector_write_element(wdata[0]), .layer_done(done[0]),
    .fsm_state(dbg[0]));

  output_memory_manager #(.BASE_ADDRESS(9'h100), .RESULT_COUNT(8)) u_b (
    .clock(clock), .clear_n(clear_n), .en(en), .results_valid(results_valid),
    .r0_element(r0), .r1_element(r1), .r2_element(r2), .r3_element(r3),
    .results_ready(ready[1]), .vector_memory_address(addr[1]), .memory_enable(mem_en[1]),
    .memory_write(mem_wr[1]), .vector_write_element(wdata[1]), .layer_done(done[1]),
    .fsm_state(dbg[1]));

  output_memory_manager #(.BASE_ADDRESS(9'h1FE), .RESULT_COUNT(144)) u_c (
    .clock(clock), .clear_n(clear_n), .en(en), .results_valid(results_valid),
    .r0_element(r0), .r1_element(r1), .r2_element(r2), .r3_element(r3),
    .results_ready(ready[2]), .vector_memory_address(addr[2]), .memory_enable(mem_en[2]),
    .memory_write(mem_wr[2]), .vector_write_element(wdata[2]), .layer_done(done[2]),
    .fsm_state(dbg[2]));

  // Scoreboard: inputs only change just after a rising edge, so the falling edge sees
  // both the outputs of the last edge and the inputs that the next edge will sample.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (exp_strobe[i]) begin
        mon_w        = exp_q[i].pop_front();
        last_addr[i] = mon_w[24:16];
        last_data[i] = mon_w[15:0];
      end
      vectors++;
      if (mem_en[i] !== exp_strobe[i] || mem_wr[i] !== exp_strobe[i] ||
          addr[i] !== last_addr[i] || wdata[i] !== last_data[i] || done[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL write_port[%0d] t=%0t: got en=%b wr=%b addr=%h data=%h done=%b, want en=%b addr=%h data=%h done=%b",
                 i, $time, mem_en[i], mem_wr[i], addr[i], wdata[i], done[i],
                 exp_strobe[i], last_addr[i], last_data[i], exp_done[i]);
      end
      // Ready: enabled, layer not fully accepted, and at most one word left to issue.
      mon_pred = en && (acc_cnt[i] != COUNT_TAB[i]) && (exp_q[i].size() <= 1);
      vectors++;
      if (ready[i] !== mon_pred) begin
        errors++;
        $display("FAIL ready[%0d] t=%0t: got %b want %b", i, $time, ready[i], mon_pred);
      end
      if (!clear_n) begin
        exp_q[i].delete();
        acc_cnt[i]    = 0;
        exp_strobe[i] = 1'b0;
        exp_done[i]   = 1'b0;
        last_addr[i]  = 9'd0;
        last_data[i]  = 16'd0;
      end else begin
        exp_strobe[i] = en && (exp_q[i].size() > 0);
        if (exp_strobe[i] && exp_q[i].size() == 1 && acc_cnt[i] == COUNT_TAB[i])
          exp_done[i] = 1'b1;
        if (results_valid && mon_pred) begin
          exp_q[i].push_back({9'((int'(BASE_TAB[i]) + acc_cnt[i] + 0) % 512), r0});
          exp_q[i].push_back({9'((int'(BASE_TAB[i]) + acc_cnt[i] + 1) % 512), r1});
          exp_q[i].push_back({9'((int'(BASE_TAB[i]) + acc_cnt[i] + 2) % 512), r2});
          exp_q[i].push_back({9'((int'(BASE_TAB[i]) + acc_cnt[i] + 3) % 512), r3});
          acc_cnt[i] += 4;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
  endtask

  // Offers a group and returns just after the edge that accepted it.
  task automatic send_group(input logic [15:0] d0, d1, d2, d3, input bit keep);
    int waited;
    waited        = 0;
    results_valid = 1'b1;
    r0 = d0; r1 = d1; r2 = d2; r3 = d3;
    @(negedge clock);
    while (ready[0] !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    vectors++;
    if (ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL send_group_timeout: ready=%b after %0d cycles, want 1", ready[0], waited);
    end
    tick();
    if (!keep) results_valid = 1'b0;
  endtask

  task automatic test_reset;
    clear_n = 1'b0; en = 1'b0; results_valid = 1'b0;
    r0 = 16'd0; r1 = 16'd0; r2 = 16'd0; r3 = 16'd0;
    repeat (2) @(posedge clock);
    #1;
    en = 1'b1;
    @(negedge clock);
    vectors++;
    if (mem_en[0] !== 1'b0 || mem_wr[0] !== 1'b0) begin
      errors++; $display("FAIL reset_strobe: en=%b wr=%b want 0 0", mem_en[0], mem_wr[0]);
    end
    vectors++;
    if (addr[0] !== 9'd0 || wdata[0] !== 16'd0) begin
      errors++; $display("FAIL reset_bus: addr=%h data=%h want 000 0000", addr[0], wdata[0]);
    end
    vectors++;
    if (done[0] !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done[0]);
    end
    vectors++;
    if (ready[0] !== 1'b1) begin
      errors++; $display("FAIL reset_idle_ready: got %b want 1", ready[0]);
    end
    tick();
    clear_n = 1'b1;
  endtask

  task automatic test_single_group;
    logic [15:0] vals  [4];
    logic [8:0]  wrapc [4];
    vals  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    wrapc = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    send_group(vals[0], vals[1], vals[2], vals[3], 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      vectors++;
      if (mem_en[0] !== (k >= 1 && k <= 4)) begin
        errors++; $display("FAIL single_strobe k=%0d: got %b want %b", k, mem_en[0], (k >= 1 && k <= 4));
      end
      if (k >= 1 && k <= 4) begin
        vectors++;
        if (addr[0] !== 9'h100 + 9'(k - 1) || wdata[0] !== vals[k-1]) begin
          errors++; $display("FAIL single_word k=%0d: got %h/%h want %h/%h", k, addr[0], wdata[0], 9'h100 + 9'(k - 1), vals[k-1]);
        end
        vectors++;
        if (addr[2] !== wrapc[k-1]) begin
          errors++; $display("FAIL wrap_addr k=%0d: got %h want %h", k, addr[2], wrapc[k-1]);
        end
      end
      vectors++;
      if (ready[0] !== (k >= 3)) begin
        errors++; $display("FAIL single_ready k=%0d: got %b want %b", k, ready[0], (k >= 3));
      end
    end
    tick();
  endtask

  task automatic test_full_layer;
    logic [15:0] g [8];
    for (int k = 0; k < 8; k++) g[k] = {4'(k), 12'($urandom)};
    do_reset();
    results_valid = 1'b1;
    r0 = g[0]; r1 = g[1]; r2 = g[2]; r3 = g[3];
    @(negedge clock);
    tick();
    r0 = g[4]; r1 = g[5]; r2 = g[6]; r3 = g[7];
    for (int k = 0; k <= 18; k++) begin
      @(negedge clock);
      if (k >= 1 && k <= 8) begin
        vectors++;
        if (mem_en[1] !== 1'b1 || addr[1] !== 9'h100 + 9'(k - 1) || wdata[1] !== g[k-1]) begin
          errors++; $display("FAIL layer_word k=%0d: got en=%b %h/%h want 1 %h/%h", k, mem_en[1], addr[1], wdata[1], 9'h100 + 9'(k - 1), g[k-1]);
        end
      end
      vectors++;
      if (done[1] !== (k >= 8)) begin
        errors++; $display("FAIL layer_done k=%0d: got %b want %b", k, done[1], (k >= 8));
      end
      if (k == 3 || k == 7 || k >= 9) begin
        vectors++;
        if (ready[1] !== (k == 3)) begin
          errors++; $display("FAIL layer_ready k=%0d: got %b want %b", k, ready[1], (k == 3));
        end
      end
      if (k >= 9) begin
        vectors++;
        if (mem_en[1] !== 1'b0) begin
          errors++; $display("FAIL done_strobe k=%0d: got %b want 0", k, mem_en[1]);
        end
      end
      tick();
      if (k == 3) begin
        r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
      end
    end
    results_valid = 1'b0;
    do_reset();
    @(negedge clock);
    vectors++;
    if (done[1] !== 1'b0) begin
      errors++; $display("FAIL done_cleared: got %b want 0", done[1]);
    end
    tick();
    g[0] = 16'($urandom);
    send_group(g[0], 16'h1, 16'h2, 16'h3, 1'b0);
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (mem_en[1] !== 1'b1 || addr[1] !== 9'h100 || wdata[1] !== g[0]) begin
      errors++; $display("FAIL relayer_first: got en=%b %h/%h want 1 100/%h", mem_en[1], addr[1], wdata[1], g[0]);
    end
    repeat (4) tick();
  endtask

  task automatic test_en_pause;
    logic [15:0] d [4];
    int widx [9];
    widx = '{-1, 0, 1, -1, -1, -1, 2, 3, -1};
    for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
    do_reset();
    send_group(d[0], d[1], d[2], d[3], 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clock);
      vectors++;
      if (mem_en[0] !== (widx[k] >= 0)) begin
        errors++; $display("FAIL pause_strobe k=%0d: got %b want %b", k, mem_en[0], (widx[k] >= 0));
      end
      if (widx[k] >= 0) begin
        vectors++;
        if (addr[0] !== 9'h100 + 9'(widx[k]) || wdata[0] !== d[widx[k]]) begin
          errors++; $display("FAIL pause_word k=%0d: got %h/%h want %h/%h", k, addr[0], wdata[0], 9'h100 + 9'(widx[k]), d[widx[k]]);
        end
      end
      if (k >= 2 && k <= 4) begin
        vectors++;
        if (ready[0] !== 1'b0) begin
          errors++; $display("FAIL pause_ready k=%0d: got %b want 0", k, ready[0]);
        end
      end
      tick();
      en = !(k >= 1 && k <= 3);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_group;
    logic [15:0] nd;
    do_reset();
    send_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      vectors++;
      if (mem_en[0] !== (k == 1 || k == 2)) begin
        errors++; $display("FAIL midreset_strobe k=%0d: got %b want %b", k, mem_en[0], (k == 1 || k == 2));
      end
      if (k == 3) begin
        vectors++;
        if (addr[0] !== 9'd0 || wdata[0] !== 16'd0 || done[0] !== 1'b0) begin
          errors++; $display("FAIL midreset_clear: got %h/%h done=%b want 000/0000 0", addr[0], wdata[0], done[0]);
        end
      end
      tick();
      clear_n = (k != 1);
    end
    nd = 16'($urandom);
    send_group(nd, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (mem_en[0] !== 1'b1 || addr[0] !== 9'h100 || wdata[0] !== nd) begin
      errors++; $display("FAIL midreset_new: got en=%b %h/%h want 1 100/%h", mem_en[0], addr[0], wdata[0], nd);
    end
    repeat (4) tick();
  endtask

  task automatic test_random;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en            = ($urandom_range(0, 9) != 0);
      results_valid = ($urandom_range(0, 3) != 0);
      r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
      clear_n = (c % 200 != 199);
      tick();
    end
    en = 1'b1; results_valid = 1'b0; clear_n = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_drain;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        errors++; $display("FAIL drain[%0d]: %0d words never written, want 0", i, exp_q[i].size());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      acc_cnt[i] = 0; exp_strobe[i] = 1'b0; exp_done[i] = 1'b0;
      last_addr[i] = 9'd0; last_data[i] = 16'd0;
    end
    test_reset();
    test_single_group();
    test_full_layer();
    test_en_pause();
    test_reset_mid_group();
    test_random();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
